// File: rtl/fifolifo_buffer.sv
// fifolifo_buffer: single-clock buffer that runs as either a FIFO or a LIFO
// stack over one DEPTH x DAT_WIDTH storage array with registered read data.
// Define FIFOLIFO_ERRFLAG_EN to build the sticky Overflow/Underflow/Mode_err
// flags; without it those outputs are constant 0 and no flag logic exists.
module fifolifo_buffer #(
    parameter int DAT_WIDTH = 32,
    parameter int L         = 6,
    parameter int DEPTH     = 64,
    parameter int AF_LEVEL  = 60
) (
    input  logic                 Wrclk,
    input  logic                 Rst,
    input  logic                 Mode,
    input  logic [DAT_WIDTH-1:0] Datain,
    input  logic                 Wren,
    input  logic                 Rden,
    output logic [DAT_WIDTH-1:0] Dataout,
    output logic                 Rdvalid,
    output logic                 Mode_act,
    output logic [L:0]           Count,
    output logic                 Full,
    output logic                 Empty,
    output logic                 Almost_full,
    output logic                 Overflow,
    output logic                 Underflow,
    output logic                 Mode_err
);

    localparam logic [L:0]   FULL_CNT = DEPTH[L:0];
    localparam logic [L:0]   AF_CNT   = AF_LEVEL[L:0];
    localparam logic [L:0]   CNT_ONE  = {{L{1'b0}}, 1'b1};
    localparam logic [L-1:0] PTR_ONE  = {{(L-1){1'b0}}, 1'b1};

    logic [DAT_WIDTH-1:0] mem [DEPTH];

    logic [L-1:0]         wr_ptr_q, wr_ptr_d;
    logic [L-1:0]         rd_ptr_q, rd_ptr_d;
    logic [L-1:0]         sp_q, sp_d;
    logic [L:0]           count_q, count_d;
    logic                 mode_act_q, mode_act_d;
    logic [DAT_WIDTH-1:0] dataout_q;
    logic                 rdvalid_q;

    logic                 rd_acc;
    logic                 wr_acc;
    logic                 mode_load;
    logic [L-1:0]         rd_addr;
    logic [L-1:0]         wr_addr;

    // Occupancy flags come straight from the registered count.
    assign Full        = (count_q == FULL_CNT);
    assign Empty       = (count_q == '0);
    assign Almost_full = (count_q >= AF_CNT);
    assign Count       = count_q;
    assign Mode_act    = mode_act_q;
    assign Dataout     = dataout_q;
    assign Rdvalid     = rdvalid_q;

    // A read at Full frees a slot, so a write in the same cycle still fits.
    assign rd_acc    = Rden && !Empty;
    assign wr_acc    = Wren && (!Full || rd_acc);
    // Mode may only switch while the buffer is empty and stays empty this edge.
    assign mode_load = (count_q == '0) && !wr_acc;

    // Address selection: LIFO pop reads top-of-stack; a simultaneous push
    // overwrites that same slot, so the stack pointer does not move.
    always_comb begin
        rd_addr = rd_ptr_q;
        wr_addr = wr_ptr_q;
        if (!mode_act_q) begin
            rd_addr = sp_q - PTR_ONE;
            wr_addr = rd_acc ? (sp_q - PTR_ONE) : sp_q;
        end
    end

    // Next-state for pointers, occupancy and active mode.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sp_d       = sp_q;
        count_d    = count_q;
        mode_act_d = mode_load ? Mode : mode_act_q;

        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_ONE;
        end

        if (mode_act_d != mode_act_q) begin
            // A mode switch only happens when empty; restart all pointers.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            sp_d     = '0;
        end else if (mode_act_q) begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            if (wr_acc && !rd_acc) begin
                sp_d = sp_q + PTR_ONE;
            end else if (rd_acc && !wr_acc) begin
                sp_d = sp_q - PTR_ONE;
            end
        end
    end

    // Storage write port; the array is left unreset so it maps onto block RAM.
    always_ff @(posedge Wrclk) begin
        if (wr_acc) mem[wr_addr] <= Datain;
    end

    // Control state and registered read data with asynchronous clear.
    always_ff @(posedge Wrclk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sp_q       <= '0;
            count_q    <= '0;
            mode_act_q <= 1'b1;
            dataout_q  <= '0;
            rdvalid_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sp_q       <= sp_d;
            count_q    <= count_d;
            mode_act_q <= mode_act_d;
            rdvalid_q  <= rd_acc;
            if (rd_acc) dataout_q <= mem[rd_addr];
        end
    end

`ifdef FIFOLIFO_ERRFLAG_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
    logic mode_err_q, mode_err_d;

    // Sticky error conditions: refused write, refused read, illegal mode request.
    always_comb begin
        overflow_d  = overflow_q  || (Wren && Full && !rd_acc);
        underflow_d = underflow_q || (Rden && Empty);
        mode_err_d  = mode_err_q  || ((Mode != mode_act_q) && (count_q != '0));
    end

    // Error flag registers, cleared only by reset.
    always_ff @(posedge Wrclk or negedge Rst) begin
        if (!Rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            mode_err_q  <= mode_err_d;
        end
    end

    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;
    assign Mode_err  = mode_err_q;
`else
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
    assign Mode_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fifolifo_buffer.sv
// Directed testbench for fifolifo_buffer (default parameters).
// Error-flag expectations follow whether FIFOLIFO_ERRFLAG_EN is defined.
module tb_fifolifo_buffer;

`ifdef FIFOLIFO_ERRFLAG_EN
    localparam logic EF = 1'b1;
`else
    localparam logic EF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [31:0] din;
    logic        wren;
    logic        rden;
    logic [31:0] dout;
    logic        rdvalid;
    logic        mode_act;
    logic [6:0]  count;
    logic        full;
    logic        empty;
    logic        afull;
    logic        ovf;
    logic        udf;
    logic        merr;

    int tests = 0;
    int fails = 0;

    fifolifo_buffer dut (
        .Wrclk       (clk),
        .Rst         (rst_n),
        .Mode        (mode),
        .Datain      (din),
        .Wren        (wren),
        .Rden        (rden),
        .Dataout     (dout),
        .Rdvalid     (rdvalid),
        .Mode_act    (mode_act),
        .Count       (count),
        .Full        (full),
        .Empty       (empty),
        .Almost_full (afull),
        .Overflow    (ovf),
        .Underflow   (udf),
        .Mode_err    (merr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance past the rising edge, then idle inputs.
    task automatic cyc(input logic w, input logic r, input logic [31:0] d);
        wren = w;
        rden = r;
        din  = d;
        @(posedge clk);
        #1;
        wren = 1'b0;
        rden = 1'b0;
    endtask

    task automatic chk_read(input string tag, input logic [31:0] exp);
        chk({tag, "_rdvalid"}, 64'(rdvalid), 64'd1);
        chk({tag, "_data"}, 64'(dout), 64'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 1'b1;
        din   = '0;
        wren  = 1'b0;
        rden  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_afull", 64'(afull), 64'd0);
        chk("rst_mode_act", 64'(mode_act), 64'd1);
        chk("rst_rdvalid", 64'(rdvalid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_flags", 64'({ovf, udf, merr}), 64'd0);
        rst_n = 1'b1;
        $display("[TB] reset checked");

        // FIFO order
        cyc(1, 0, 32'h11);
        cyc(1, 0, 32'h22);
        cyc(1, 0, 32'h33);
        chk("fifo_count3", 64'(count), 64'd3);
        cyc(0, 1, 0); chk_read("fifo_rd0", 32'h11);
        cyc(0, 1, 0); chk_read("fifo_rd1", 32'h22);
        cyc(0, 1, 0); chk_read("fifo_rd2", 32'h33);
        chk("fifo_empty", 64'(empty), 64'd1);
        cyc(0, 0, 0);
        chk("idle_rdvalid", 64'(rdvalid), 64'd0);
        chk("idle_hold", 64'(dout), 64'h33);
        $display("[TB] fifo order checked");

        // Mode change refused while occupied
        cyc(1, 0, 32'h44);
        cyc(1, 0, 32'h55);
        chk("merr_before", 64'(merr), 64'd0);
        mode = 1'b0;
        cyc(0, 0, 0);
        chk("mode_hold", 64'(mode_act), 64'd1);
        chk("mode_err", 64'(merr), 64'(EF));
        chk("mode_err_count", 64'(count), 64'd2);
        mode = 1'b1;
        cyc(0, 1, 0); chk_read("merr_rd0", 32'h44);
        cyc(0, 1, 0); chk_read("merr_rd1", 32'h55);
        chk("udf_before", 64'(udf), 64'd0);
        // Read on empty
        cyc(0, 1, 0);
        chk("udf_rdvalid", 64'(rdvalid), 64'd0);
        chk("udf_dout", 64'(dout), 64'h55);
        chk("udf_flag", 64'(udf), 64'(EF));
        $display("[TB] mode error / underflow checked");

        // LIFO order
        mode = 1'b0;
        cyc(0, 0, 0);
        chk("lifo_mode_act", 64'(mode_act), 64'd0);
        cyc(1, 0, 32'hA);
        cyc(1, 0, 32'hB);
        cyc(1, 0, 32'hC);
        cyc(0, 1, 0); chk_read("lifo_rd0", 32'hC);
        cyc(0, 1, 0); chk_read("lifo_rd1", 32'hB);
        cyc(0, 1, 0); chk_read("lifo_rd2", 32'hA);
        chk("lifo_empty", 64'(empty), 64'd1);
        // LIFO simultaneous push/pop replaces top of stack
        cyc(1, 0, 32'h1);
        cyc(1, 0, 32'h2);
        cyc(1, 1, 32'h3); chk_read("lifo_swap", 32'h2);
        chk("lifo_swap_count", 64'(count), 64'd2);
        cyc(0, 1, 0); chk_read("lifo_swap_rd0", 32'h3);
        cyc(0, 1, 0); chk_read("lifo_swap_rd1", 32'h1);
        $display("[TB] lifo order checked");

        // FIFO full boundary
        mode = 1'b1;
        cyc(0, 0, 0);
        chk("fifo_mode_act", 64'(mode_act), 64'd1);
        for (int i = 0; i < 64; i++) begin
            cyc(1, 0, 32'h100 + 32'(i));
            if (i == 58) chk("afull_59", 64'(afull), 64'd0);
            if (i == 59) chk("afull_60", 64'(afull), 64'd1);
            if (i == 62) chk("full_63", 64'(full), 64'd0);
        end
        chk("full_64", 64'(full), 64'd1);
        chk("count_64", 64'(count), 64'd64);
        chk("ovf_before", 64'(ovf), 64'd0);
        cyc(1, 0, 32'hDEAD);
        chk("ovf_count", 64'(count), 64'd64);
        chk("ovf_flag", 64'(ovf), 64'(EF));
        chk("ovf_rdvalid", 64'(rdvalid), 64'd0);
        cyc(1, 1, 32'h200); chk_read("fifo_full_rw", 32'h100);
        chk("fifo_full_rw_count", 64'(count), 64'd64);
        for (int i = 1; i < 64; i++) begin
            cyc(0, 1, 0);
            chk_read($sformatf("fifo_drain%0d", i), 32'h100 + 32'(i));
        end
        cyc(0, 1, 0); chk_read("fifo_drain_last", 32'h200);
        chk("fifo_drain_empty", 64'(empty), 64'd1);
        $display("[TB] fifo full boundary checked");

        // LIFO full boundary
        mode = 1'b0;
        cyc(0, 0, 0);
        for (int i = 0; i < 64; i++) cyc(1, 0, 32'h300 + 32'(i));
        chk("lifo_full", 64'(full), 64'd1);
        cyc(1, 1, 32'h400); chk_read("lifo_full_rw", 32'h33F);
        chk("lifo_full_rw_count", 64'(count), 64'd64);
        cyc(0, 1, 0); chk_read("lifo_top", 32'h400);
        for (int i = 62; i >= 0; i--) begin
            cyc(0, 1, 0);
            chk_read($sformatf("lifo_drain%0d", i), 32'h300 + 32'(i));
        end
        chk("lifo_drain_empty", 64'(empty), 64'd1);
        $display("[TB] lifo full boundary checked");

        // FIFO wrap-around with one word in flight
        mode = 1'b1;
        cyc(0, 0, 0);
        cyc(1, 0, 32'hA500_0000);
        for (int i = 1; i < 100; i++) begin
            cyc(1, 1, 32'hA500_0000 ^ 32'(i));
            chk_read($sformatf("wrap%0d", i), 32'hA500_0000 ^ 32'(i - 1));
        end
        chk("wrap_count", 64'(count), 64'd1);
        cyc(0, 1, 0); chk_read("wrap_last", 32'hA500_0000 ^ 32'd99);
        $display("[TB] wrap-around checked");

        // Reset mid-operation
        for (int i = 0; i < 5; i++) cyc(1, 0, 32'h60 + 32'(i));
        chk("pre_rst_count", 64'(count), 64'd5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_dout", 64'(dout), 64'd0);
        chk("mid_rst_rdvalid", 64'(rdvalid), 64'd0);
        chk("mid_rst_mode_act", 64'(mode_act), 64'd1);
        chk("mid_rst_flags", 64'({ovf, udf, merr}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0);
            chk($sformatf("post_rst_rdvalid%0d", i), 64'(rdvalid), 64'd0);
        end
        cyc(1, 0, 32'h77);
        cyc(0, 1, 0); chk_read("post_rst_rd", 32'h77);
        $display("[TB] mid-operation reset checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifolifo_buffer.md
FIFOLIFO_BUFFER -- requirements
Module: fifolifo_buffer

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter L, default 6, pointer width; DEPTH SHALL equal 2**L.
REQ-003 SHALL have parameter DEPTH, default 64, number of storage entries.
REQ-004 SHALL have parameter AF_LEVEL, default 60, occupancy at or above which Almost_full is asserted.
REQ-005 SHALL have ports, one per line:
- Wrclk  in  1  single clock; all state updates on its rising edge
- Rst  in  1  asynchronous, active-low reset
- Mode  in  1  requested mode: 1 = FIFO, 0 = LIFO
- Datain  in  DAT_WIDTH  write data
- Wren  in  1  write (push) request
- Rden  in  1  read (pop) request
- Dataout  out  DAT_WIDTH  registered read data
- Rdvalid  out  1  one-cycle pulse: Dataout updated this cycle
- Mode_act  out  1  mode currently in force
- Count  out  L+1  current occupancy, 0..DEPTH
- Full, Empty, Almost_full  out  1 each  occupancy flags
- Overflow, Underflow, Mode_err  out  1 each  sticky error flags (see REQ-020)

Function
REQ-006 Storage SHALL be a DEPTH x DAT_WIDTH array addressed by L-bit pointers that wrap modulo DEPTH.
REQ-007 Full SHALL equal (Count==DEPTH), Empty SHALL equal (Count==0), Almost_full SHALL equal (Count>=AF_LEVEL); all derived from registered Count with no extra latency.
REQ-008 A write SHALL be accepted when Wren=1 and either Full=0, or Full=1 with an accepted read in the same cycle.
REQ-009 A read SHALL be accepted when Rden=1 and Empty=0; read latency SHALL be 1 cycle: Dataout loads and Rdvalid=1 on the edge that accepts the read.
REQ-010 Dataout SHALL hold its last value when no read is accepted; Rdvalid SHALL be 0 in that cycle.
REQ-011 FIFO mode: write at wr_ptr then wr_ptr+1; read from rd_ptr then rd_ptr+1; simultaneous accepted read and write SHALL leave Count unchanged, including at Full.
REQ-012 LIFO mode: a single pointer sp SHALL index the next free slot; push writes mem[sp], sp+1; pop returns mem[sp-1], sp-1.
REQ-013 LIFO simultaneous push and pop SHALL return the pre-edge top of stack and write Datain into that same slot; sp and Count unchanged.
REQ-014 Wren=1 and Rden=1 while Empty SHALL perform the write only, and SHALL flag Underflow.
REQ-015 Mode_act SHALL load from Mode only on an edge where Count==0 and no write is accepted; otherwise Mode_act SHALL hold.
REQ-016 Mode differing from Mode_act while Count!=0 SHALL set Mode_err; contents and pointers SHALL be unaffected.
REQ-017 On a Mode_act change all pointers SHALL be zeroed.
REQ-018 Count SHALL increment on write-only, decrement on read-only, hold otherwise; it SHALL never exceed DEPTH or go below 0.

Reset
REQ-019 Rst=0 SHALL asynchronously force: pointers, Count, Dataout, Rdvalid, Overflow, Underflow, Mode_err to 0; Mode_act to 1 (FIFO); Empty=1, Full=0, Almost_full=0. Memory contents need not be cleared; reset mid-operation SHALL discard all stored data.

Configuration
REQ-020 Macro FIFOLIFO_ERRFLAG_EN defined: Overflow sets on Wren=1 refused at Full, Underflow sets on Rden=1 refused at Empty, Mode_err per REQ-016; all three sticky until reset. Macro undefined: the three outputs SHALL be tied to 0 and no flag logic SHALL be synthesised; all other behaviour identical.

Verification
REQ-021 FIFO order: Mode=1, write 0x11,0x22,0x33, then 3 reads -> Dataout 0x11,0x22,0x33 on consecutive cycles with Rdvalid=1 each, Empty=1 after.
REQ-022 LIFO order: Mode=0 while empty, push 0xA,0xB,0xC, 3 pops -> Dataout 0xC,0xB,0xA, Mode_act=0.
REQ-023 Full boundary: fill 64 words -> Full=1, Count=64, Almost_full=1 from Count=60; 65th write ignored, Overflow=1 (macro on); simultaneous read+write at Full in each mode -> Count stays 64, correct word returned.
REQ-024 Wrap-around: FIFO, 100 interleaved write/read pairs with distinct data -> every word returned in order, pointers wrap past 63 without loss.
REQ-025 Mode/underflow: with Count=2 drive Mode=0 -> Mode_act stays 1, Mode_err=1; read on empty -> Underflow=1, Rdvalid=0, Dataout unchanged.
REQ-026 Reset mid-operation: Count=5, drop Rst between edges -> outputs reach REQ-019 values immediately, no Rdvalid after release until new data written.
